// File: rtl/watch_time_ctrl.sv
// Timebase and set-time controller: 1 Hz seconds, minute/hour tick pulses,
// debounced mode/inc buttons driving a RUN / SET_HH / SET_MM state machine.
module watch_time_ctrl #(
    parameter int TICKS_PER_SEC = 32768,
    parameter int DEBOUNCE_CYC  = 1024,
    parameter int TIMEOUT_S     = 30
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       min_carry_i,
    output logic [5:0] sec_o,
    output logic       sec_tick_o,
    output logic       min_tick_o,
    output logic       hour_tick_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYC);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_S);

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_SET_HH = 2'b01;
    localparam logic [1:0] MODE_SET_MM = 2'b10;

    // Bit 0 = mode button, bit 1 = inc button
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_inc_i, btn_mode_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg + 1'b1 == DEB_MAX) begin
                        // Level accepted; only a 0->1 change is a press
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic          mode_press;
    logic          inc_press;
    logic          sec_event;
    logic [PW-1:0] presc_adv;

    logic [1:0]    mode_reg;
    logic [PW-1:0] presc_reg;
    logic [5:0]    sec_reg;
    logic [TW-1:0] to_reg;
    logic          sec_tick_reg;
    logic          min_tick_reg;
    logic          hour_tick_reg;

    // Mode wins when both buttons are accepted on the same cycle
    assign mode_press = press[0];
    assign inc_press  = press[1] & ~press[0];
    assign sec_event  = (presc_reg == PRESC_MAX);
    assign presc_adv  = sec_event ? '0 : presc_reg + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_reg      <= MODE_RUN;
            presc_reg     <= '0;
            sec_reg       <= '0;
            to_reg        <= '0;
            sec_tick_reg  <= 1'b0;
            min_tick_reg  <= 1'b0;
            hour_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg  <= 1'b0;
            min_tick_reg  <= 1'b0;
            hour_tick_reg <= 1'b0;
            presc_reg     <= presc_adv;
            case (mode_reg)
                MODE_RUN: begin
                    if (mode_press) begin
                        mode_reg  <= MODE_SET_HH;
                        presc_reg <= '0;
                        sec_reg   <= '0;
                        to_reg    <= '0;
                    end else if (sec_event) begin
                        sec_tick_reg <= 1'b1;
                        if (sec_reg == 6'd59) begin
                            sec_reg       <= '0;
                            min_tick_reg  <= 1'b1;
                            hour_tick_reg <= min_carry_i;
                        end else begin
                            sec_reg <= sec_reg + 6'd1;
                        end
                    end
                end
                MODE_SET_HH, MODE_SET_MM: begin
                    if (mode_press || inc_press) begin
                        to_reg <= '0;
                        if (mode_press) begin
                            if (mode_reg == MODE_SET_HH) begin
                                mode_reg <= MODE_SET_MM;
                            end else begin
                                mode_reg  <= MODE_RUN;
                                presc_reg <= '0;
                                sec_reg   <= '0;
                            end
                        end else if (mode_reg == MODE_SET_HH) begin
                            hour_tick_reg <= 1'b1;
                        end else begin
                            min_tick_reg <= 1'b1;
                        end
                    end else if (sec_event) begin
                        if (to_reg + 1'b1 == TO_MAX) begin
                            mode_reg  <= MODE_RUN;
                            presc_reg <= '0;
                            sec_reg   <= '0;
                            to_reg    <= '0;
                        end else begin
                            to_reg <= to_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    mode_reg  <= MODE_RUN;
                    presc_reg <= '0;
                    sec_reg   <= '0;
                    to_reg    <= '0;
                end
            endcase
        end
    end

    assign sec_o       = sec_reg;
    assign sec_tick_o  = sec_tick_reg;
    assign min_tick_o  = min_tick_reg;
    assign hour_tick_o = hour_tick_reg;
    assign mode_o      = mode_reg;
    assign blink_o     = (mode_reg != MODE_RUN) && (presc_reg < PRESC_HALF);

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Scenario bench for watch_time_ctrl with an event-level reference model.
module tb_watch_time_ctrl;

    localparam int T  = 4;
    localparam int D  = 3;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bm = 1'b0;
    logic       bi = 1'b0;
    logic       mc = 1'b0;
    logic [5:0] sec_o;
    logic       sec_tick_o, min_tick_o, hour_tick_o, blink_o;
    logic [1:0] mode_o;

    watch_time_ctrl #(.TICKS_PER_SEC(T), .DEBOUNCE_CYC(D), .TIMEOUT_S(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_mode_i(bm), .btn_inc_i(bi),
        .min_carry_i(mc), .sec_o(sec_o), .sec_tick_o(sec_tick_o),
        .min_tick_o(min_tick_o), .hour_tick_o(hour_tick_o),
        .mode_o(mode_o), .blink_o(blink_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=RUN 1=SET_HH 2=SET_MM
    int m_presc, m_sec, m_mode, m_to;
    bit m_st, m_mt, m_ht, m_pm, m_pi, lvl_m, lvl_i;
    bit hist_m[$];
    bit hist_i[$];
    int n_st, n_mt, n_ht;

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_mode = 0; m_to = 0;
        m_st = 0; m_mt = 0; m_ht = 0; m_pm = 0; m_pi = 0;
        lvl_m = 0; lvl_i = 0;
        hist_m.delete(); hist_i.delete();
        for (int k = 0; k < D + 1; k++) begin
            hist_m.push_back(1'b0);
            hist_i.push_back(1'b0);
        end
    endtask

    // A level is accepted once D raw samples, seen through the 2-flop
    // synchronizer, all disagree with the current accepted level.
    task automatic model_edge(input bit rm, input bit ri, input bit c);
        bit all_m, all_i, new_pm, new_pi, ev;
        int pn;
        hist_m.push_back(rm);
        hist_i.push_back(ri);
        all_m = 1; all_i = 1;
        for (int k = 0; k < D; k++) begin
            if (hist_m[k] == lvl_m) all_m = 0;
            if (hist_i[k] == lvl_i) all_i = 0;
        end
        new_pm = 0; new_pi = 0;
        if (all_m) begin lvl_m = !lvl_m; new_pm = lvl_m; end
        if (all_i) begin lvl_i = !lvl_i; new_pi = lvl_i; end
        void'(hist_m.pop_front());
        void'(hist_i.pop_front());

        ev = (m_presc == T - 1);
        pn = (m_presc + 1) % T;
        m_st = 0; m_mt = 0; m_ht = 0;
        if (m_mode == 0) begin
            if (m_pm) begin
                m_mode = 1; m_presc = 0; m_sec = 0; m_to = 0;
            end else begin
                m_presc = pn;
                if (ev) begin
                    m_st = 1;
                    m_sec = m_sec + 1;
                    if (m_sec == 60) begin m_sec = 0; m_mt = 1; m_ht = c; end
                end
            end
        end else begin
            m_presc = pn;
            if (m_pm || m_pi) begin
                m_to = 0;
                if (m_pm) begin
                    if (m_mode == 1) m_mode = 2;
                    else begin m_mode = 0; m_presc = 0; m_sec = 0; end
                end else if (m_mode == 1) m_ht = 1;
                else m_mt = 1;
            end else if (ev) begin
                m_to = m_to + 1;
                if (m_to == TO) begin m_mode = 0; m_presc = 0; m_sec = 0; m_to = 0; end
            end
        end
        m_pm = new_pm;
        m_pi = new_pi && !new_pm;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bm, bi, mc);
        #1;
        if (sec_tick_o === 1'b1) n_st++;
        if (min_tick_o === 1'b1) n_mt++;
        if (hour_tick_o === 1'b1) n_ht++;
    endtask

    task automatic clear_counts();
        n_st = 0; n_mt = 0; n_ht = 0;
    endtask

    task automatic pulse_btn(input bit pm, input bit pi, input int hold, input int gap);
        bm = pm; bi = pi;
        repeat (hold) step();
        bm = 0; bi = 0;
        repeat (gap) step();
    endtask

    task automatic test_reset();
        rst_n = 0; bm = 0; bi = 0; mc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({sec_o, sec_tick_o, min_tick_o, hour_tick_o, mode_o, blink_o} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {sec_o, sec_tick_o, min_tick_o, hour_tick_o, mode_o, blink_o});
        end
        rst_n = 1;
        step();
        tests++;
        if (mode_o !== 2'b00 || sec_o !== 6'd0) begin
            fails++;
            $display("FAIL reset_release mode=%0d sec=%0d exp 0/0", mode_o, sec_o);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_free_run(input bit carry);
        mc = carry;
        clear_counts();
        for (int c = 0; c < 240; c++) begin
            step();
            tests++;
            if (sec_o !== 6'(m_sec) || sec_tick_o !== m_st || min_tick_o !== m_mt || hour_tick_o !== m_ht) begin
                fails++;
                $display("FAIL free_run cyc=%0d got sec=%0d st=%b mt=%b ht=%b exp sec=%0d st=%b mt=%b ht=%b",
                         c, sec_o, sec_tick_o, min_tick_o, hour_tick_o, m_sec, m_st, m_mt, m_ht);
            end
        end
        tests++;
        if (n_st != 60) begin fails++; $display("FAIL free_sec_ticks got=%0d exp=60", n_st); end
        tests++;
        if (n_mt != 1) begin fails++; $display("FAIL free_min_ticks got=%0d exp=1", n_mt); end
        tests++;
        if (n_ht != int'(carry)) begin fails++; $display("FAIL free_hour_ticks got=%0d exp=%0d", n_ht, carry); end
        $display("[TB] free run carry=%0d sec_ticks=%0d min_ticks=%0d hour_ticks=%0d", carry, n_st, n_mt, n_ht);
        mc = 0;
    endtask

    task automatic test_mode_enter();
        int first_j, trans, ent_sec;
        logic [1:0] prev;
        bm = 1; step(); bm = 0;
        repeat (8) step();
        tests++;
        if (mode_o !== 2'b00) begin fails++; $display("FAIL glitch_mode got=%0d exp=0", mode_o); end
        first_j = 0; trans = 0; ent_sec = -1; prev = mode_o;
        bm = 1;
        for (int j = 1; j <= 16; j++) begin
            if (j == 11) bm = 0;
            step();
            if (mode_o == 2'b01 && prev != 2'b01) begin
                trans++;
                if (first_j == 0) begin first_j = j; ent_sec = int'(sec_o); end
            end
            prev = mode_o;
            if (j > 10) begin
                tests++;
                if (blink_o !== ((m_mode != 0) && (m_presc < T / 2))) begin
                    fails++;
                    $display("FAIL blink j=%0d got=%b exp=%b", j, blink_o, ((m_mode != 0) && (m_presc < T / 2)));
                end
            end
        end
        tests++;
        if (first_j != 2 + D + 1) begin fails++; $display("FAIL mode_latency got=%0d exp=%0d", first_j, 2 + D + 1); end
        tests++;
        if (trans != 1) begin fails++; $display("FAIL mode_once got=%0d exp=1", trans); end
        tests++;
        if (ent_sec != 0) begin fails++; $display("FAIL entry_sec got=%0d exp=0", ent_sec); end
        $display("[TB] mode enter latency=%0d transitions=%0d", first_j, trans);
    endtask

    task automatic test_set_inc();
        clear_counts();
        repeat (3) pulse_btn(0, 1, 4, 6);
        tests++;
        if (n_ht != 3 || n_mt != 0) begin fails++; $display("FAIL hh_inc got ht=%0d mt=%0d exp 3/0", n_ht, n_mt); end
        pulse_btn(1, 0, 4, 6);
        tests++;
        if (mode_o !== 2'b10) begin fails++; $display("FAIL to_set_mm got=%0d exp=2", mode_o); end
        mc = 1;
        clear_counts();
        repeat (2) pulse_btn(0, 1, 4, 6);
        tests++;
        if (n_mt != 2 || n_ht != 0) begin fails++; $display("FAIL mm_inc got mt=%0d ht=%0d exp 2/0", n_mt, n_ht); end
        mc = 0;
        pulse_btn(1, 0, 4, 2);
        tests++;
        if (mode_o !== 2'b00 || sec_o !== 6'd0) begin
            fails++;
            $display("FAIL exit_run got mode=%0d sec=%0d exp 0/0", mode_o, sec_o);
        end
        repeat (4) step();
        $display("[TB] set inc hour/min presses done mode=%0d", mode_o);
    endtask

    task automatic test_timeout();
        int e2, e0;
        logic [1:0] prev;
        pulse_btn(1, 0, 4, 6);
        e2 = 0; e0 = 0; prev = mode_o;
        bm = 1;
        for (int j = 1; j <= 40; j++) begin
            if (j == 5) bm = 0;
            step();
            if (mode_o == 2'b10 && prev != 2'b10 && e2 == 0) e2 = j;
            if (mode_o == 2'b00 && prev != 2'b00 && e0 == 0) e0 = j;
            prev = mode_o;
            tests++;
            if (mode_o !== 2'(m_mode)) begin fails++; $display("FAIL timeout_mode j=%0d got=%0d exp=%0d", j, mode_o, m_mode); end
        end
        tests++;
        if (e2 != 6) begin fails++; $display("FAIL timeout_enter_mm got=%0d exp=6", e2); end
        tests++;
        if (e0 - e2 < 4 * TO - 3 || e0 - e2 > 4 * TO) begin
            fails++;
            $display("FAIL timeout_delay got=%0d exp=%0d..%0d", e0 - e2, 4 * TO - 3, 4 * TO);
        end
        tests++;
        if (mode_o !== 2'b00 || blink_o !== 1'b0) begin fails++; $display("FAIL timeout_end mode=%0d blink=%b exp 0/0", mode_o, blink_o); end
        $display("[TB] timeout after %0d cycles in SET_MM", e0 - e2);
    endtask

    task automatic test_back_to_back();
        mc = 1;
        clear_counts();
        pulse_btn(1, 1, 4, 6);
        tests++;
        if (mode_o !== 2'b01 || n_ht != 0) begin fails++; $display("FAIL both_run got mode=%0d ht=%0d exp 1/0", mode_o, n_ht); end
        clear_counts();
        pulse_btn(1, 1, 4, 6);
        tests++;
        if (mode_o !== 2'b10 || n_ht != 0 || n_mt != 0) begin
            fails++;
            $display("FAIL both_hh got mode=%0d ht=%0d mt=%0d exp 2/0/0", mode_o, n_ht, n_mt);
        end
        pulse_btn(1, 0, 4, 6);
        tests++;
        if (mode_o !== 2'b00) begin fails++; $display("FAIL both_back_run got=%0d exp=0", mode_o); end
        mc = 0;
        $display("[TB] simultaneous presses done");
    endtask

    task automatic test_random();
        int seg_left, bounce, errs;
        bit tgt_m, tgt_i;
        seg_left = 0; bounce = 0; errs = 0; tgt_m = 0; tgt_i = 0;
        for (int c = 0; c < 1500; c++) begin
            if (seg_left == 0) begin
                tgt_m = ($urandom_range(0, 7) == 0);
                tgt_i = ($urandom_range(0, 3) == 0);
                seg_left = $urandom_range(3, 25);
                bounce = $urandom_range(0, 3);
                mc = 1'($urandom_range(0, 1));
            end
            bm = (bounce > 0) ? 1'($urandom_range(0, 1)) : tgt_m;
            bi = (bounce > 0) ? 1'($urandom_range(0, 1)) : tgt_i;
            if (bounce > 0) bounce--;
            seg_left--;
            step();
            tests++;
            if (sec_o !== 6'(m_sec) || sec_tick_o !== m_st || min_tick_o !== m_mt || hour_tick_o !== m_ht ||
                mode_o !== 2'(m_mode) || blink_o !== ((m_mode != 0) && (m_presc < T / 2))) begin
                fails++; errs++;
                $display("FAIL random cyc=%0d got sec=%0d st=%b mt=%b ht=%b mode=%0d bl=%b exp sec=%0d st=%b mt=%b ht=%b mode=%0d",
                         c, sec_o, sec_tick_o, min_tick_o, hour_tick_o, mode_o, blink_o, m_sec, m_st, m_mt, m_ht, m_mode);
            end
        end
        bm = 0; bi = 0; mc = 0;
        repeat (8) step();
        $display("[TB] random 1500 cycles, %0d mismatching cycles", errs);
    endtask

    task automatic test_reset_mid();
        pulse_btn(1, 0, 4, 6);
        pulse_btn(1, 0, 4, 6);
        tests++;
        if (mode_o !== 2'(m_mode)) begin fails++; $display("FAIL pre_reset_mode got=%0d exp=%0d", mode_o, m_mode); end
        for (int j = 0; j < 5; j++) begin
            bi = 1'($urandom_range(0, 1));
            step();
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if ({sec_o, sec_tick_o, min_tick_o, hour_tick_o, mode_o, blink_o} !== 12'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {sec_o, sec_tick_o, min_tick_o, hour_tick_o, mode_o, blink_o});
        end
        model_reset();
        repeat (2) begin
            @(negedge clk);
            bi = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bi = 0;
        rst_n = 1;
        for (int j = 0; j < 12; j++) begin
            step();
            tests++;
            if (mode_o !== 2'(m_mode) || sec_o !== 6'(m_sec) || hour_tick_o !== m_ht || min_tick_o !== m_mt) begin
                fails++;
                $display("FAIL post_reset j=%0d got mode=%0d sec=%0d exp mode=%0d sec=%0d", j, mode_o, sec_o, m_mode, m_sec);
            end
        end
        $display("[TB] mid-operation reset done mode=%0d", mode_o);
    endtask

    initial begin
        test_reset();
        test_free_run(1'b0);
        test_free_run(1'b1);
        test_mode_enter();
        test_set_inc();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
